rv32i_regtop: RTL and testbench

Register-file block of the RV32I pipeline, and the receiving end of the writeback interface. It stores x1–x31, accepts one write per cycle from the writeback stage, and serves two combinational read ports to Instruction Decode. A per-register pending-write scoreboard lets Decode detect read-after-write hazards and stall until the producing instruction reaches writeback.

---
 rtl/rv32i_regtop_if.sv | 28 ++
 rtl/rv32i_regtop.sv | 94 +++++++++
 tb/tb_rv32i_regtop.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/rv32i_regtop_if.sv
// Writeback and Decode signal bundle for the RV32I register file.
// slave is the register-file side; master is the pipeline side driving it.
interface rv32i_regtop_if;
    logic        wb_en_in;
    logic [4:0]  wb_reg_in;
    logic [31:0] wb_data_in;
    logic [4:0]  rs1_reg;
    logic [4:0]  rs2_reg;
    logic        rs1_used;
    logic        rs2_used;
    logic        issue_en;
    logic [4:0]  issue_reg;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic        stall;

    modport master (
        output wb_en_in, wb_reg_in, wb_data_in,
        output rs1_reg, rs2_reg, rs1_used, rs2_used, issue_en, issue_reg,
        input  rs1_data, rs2_data, stall
    );

    modport slave (
        input  wb_en_in, wb_reg_in, wb_data_in,
        input  rs1_reg, rs2_reg, rs1_used, rs2_used, issue_en, issue_reg,
        output rs1_data, rs2_data, stall
    );
endinterface

// File: rtl/rv32i_regtop.sv
// RV32I register file with two combinational read ports and a per-register pending-write
// scoreboard for RAW stalls. Define REGFILE_BYPASS_EN for same-cycle writeback bypass.
module rv32i_regtop (
    input logic           clk,
    input logic           reset,
    rv32i_regtop_if.slave rf
);
    logic [31:0] regs_q  [1:31];
    logic [1:0]  pend_q  [1:31];
    logic [1:0]  pend_d  [1:31];
    logic [31:0] regs_rd [32];
    logic [1:0]  pend_rd [32];
    logic        wb_qual;
    logic        issue_qual;
    logic        issue_full;
    logic        haz1;
    logic        haz2;

    // Index 0 is hard-wired so every 5-bit address has a defined entry.
    always_comb begin
        regs_rd[0] = '0;
        pend_rd[0] = '0;
        for (int i = 1; i < 32; i++) begin
            regs_rd[i] = regs_q[i];
            pend_rd[i] = pend_q[i];
        end
    end

    assign wb_qual = rf.wb_en_in & (rf.wb_reg_in != 5'd0);

`ifdef REGFILE_BYPASS_EN
    logic wb_hit1;
    logic wb_hit2;
    logic clear1;
    logic clear2;

    // A write retiring the last pending producer releases the reader in the same cycle.
    always_comb begin
        wb_hit1 = wb_qual & (rf.wb_reg_in == rf.rs1_reg);
        wb_hit2 = wb_qual & (rf.wb_reg_in == rf.rs2_reg);
        clear1  = wb_hit1 & (pend_rd[rf.rs1_reg] == 2'd1)
                  & ~(rf.issue_en & (rf.issue_reg == rf.rs1_reg));
        clear2  = wb_hit2 & (pend_rd[rf.rs2_reg] == 2'd1)
                  & ~(rf.issue_en & (rf.issue_reg == rf.rs2_reg));
        rf.rs1_data = wb_hit1 ? rf.wb_data_in : regs_rd[rf.rs1_reg];
        rf.rs2_data = wb_hit2 ? rf.wb_data_in : regs_rd[rf.rs2_reg];
        haz1 = rf.rs1_used & (rf.rs1_reg != 5'd0) & (pend_rd[rf.rs1_reg] != 2'd0) & ~clear1;
        haz2 = rf.rs2_used & (rf.rs2_reg != 5'd0) & (pend_rd[rf.rs2_reg] != 2'd0) & ~clear2;
    end
`else
    always_comb begin
        rf.rs1_data = regs_rd[rf.rs1_reg];
        rf.rs2_data = regs_rd[rf.rs2_reg];
        haz1 = rf.rs1_used & (rf.rs1_reg != 5'd0) & (pend_rd[rf.rs1_reg] != 2'd0);
        haz2 = rf.rs2_used & (rf.rs2_reg != 5'd0) & (pend_rd[rf.rs2_reg] != 2'd0);
    end
`endif

    assign issue_full = rf.issue_en & (rf.issue_reg != 5'd0) & (pend_rd[rf.issue_reg] == 2'd3);
    assign rf.stall   = haz1 | haz2 | issue_full;
    // An issue attempted under stall is dropped.
    assign issue_qual = rf.issue_en & (rf.issue_reg != 5'd0) & ~rf.stall;

    always_comb begin
        for (int i = 1; i < 32; i++) begin
            logic inc;
            logic dec;
            inc = issue_qual & (rf.issue_reg == 5'(i));
            dec = wb_qual & (rf.wb_reg_in == 5'(i));
            pend_d[i] = pend_q[i];
            if (inc && !dec && (pend_q[i] != 2'd3)) begin
                pend_d[i] = pend_q[i] + 2'd1;
            end else if (dec && !inc && (pend_q[i] != 2'd0)) begin
                pend_d[i] = pend_q[i] - 2'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 1; i < 32; i++) begin
                regs_q[i] <= '0;
                pend_q[i] <= '0;
            end
        end else begin
            for (int i = 1; i < 32; i++) begin
                pend_q[i] <= pend_d[i];
                if (wb_qual && (rf.wb_reg_in == 5'(i))) begin
                    regs_q[i] <= rf.wb_data_in;
                end
            end
        end
    end
endmodule

// File: tb/tb_rv32i_regtop.sv
// Directed bench for rv32i_regtop: expected read data and stall are queued per step and
// compared against the DUT outputs; expectations follow REGFILE_BYPASS_EN when defined.
module tb_rv32i_regtop;
`ifdef REGFILE_BYPASS_EN
    localparam bit Byp = 1'b1;
`else
    localparam bit Byp = 1'b0;
`endif

    typedef struct {
        string       tag;
        logic [31:0] r1;
        logic [31:0] r2;
        logic        st;
    } exp_t;

    logic   clk;
    logic   reset;
    exp_t   sb[$];
    int     n_cmp;
    int     n_err;

    rv32i_regtop_if bus ();

    rv32i_regtop dut (
        .clk   (clk),
        .reset (reset),
        .rf    (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic compare_front();
        exp_t e;
        if (sb.size() == 0) begin
            n_err++;
            $error("FAIL scoreboard: got empty queue expected an entry");
            return;
        end
        e = sb.pop_front();
        n_cmp += 3;
        assert (bus.rs1_data === e.r1) else begin
            n_err++;
            $error("FAIL %s rs1_data: got %h expected %h", e.tag, bus.rs1_data, e.r1);
        end
        assert (bus.rs2_data === e.r2) else begin
            n_err++;
            $error("FAIL %s rs2_data: got %h expected %h", e.tag, bus.rs2_data, e.r2);
        end
        assert (bus.stall === e.st) else begin
            n_err++;
            $error("FAIL %s stall: got %b expected %b", e.tag, bus.stall, e.st);
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] e1, input logic [31:0] e2,
                       input logic es);
        exp_t e;
        e.tag = tag;
        e.r1  = e1;
        e.r2  = e2;
        e.st  = es;
        sb.push_back(e);
        #1;
        compare_front();
    endtask

    task automatic wb(input logic [4:0] r, input logic [31:0] d);
        bus.wb_en_in   = 1'b1;
        bus.wb_reg_in  = r;
        bus.wb_data_in = d;
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        reset = 1'b0;
        bus.wb_en_in   = 1'b0;
        bus.wb_reg_in  = '0;
        bus.wb_data_in = '0;
        bus.rs1_reg    = '0;
        bus.rs2_reg    = '0;
        bus.rs1_used   = 1'b0;
        bus.rs2_used   = 1'b0;
        bus.issue_en   = 1'b0;
        bus.issue_reg  = '0;

        // Reset state and every address reads zero
        #1;
        chk("reset", 32'h0, 32'h0, 1'b0);
        for (int i = 0; i < 32; i++) begin
            bus.rs1_reg = 5'(i);
            chk($sformatf("reset_rd_x%0d", i), 32'h0, 32'h0, 1'b0);
        end
        @(posedge clk);
        #3;
        reset = 1'b1;
        tick();

        // Writes to x0 are discarded
        bus.rs1_reg = 5'd0;
        wb(5'd0, 32'hDEADBEEF);
        chk("x0_pre", 32'h0, 32'h0, 1'b0);
        tick();
        bus.wb_en_in = 1'b0;
        chk("x0_post", 32'h0, 32'h0, 1'b0);

        // Write/read x5
        bus.rs1_reg = 5'd5;
        wb(5'd5, 32'h12345678);
        chk("wr_pre", Byp ? 32'h12345678 : 32'h0, 32'h0, 1'b0);
        tick();
        bus.wb_en_in = 1'b0;
        chk("wr_post", 32'h12345678, 32'h0, 1'b0);

        // RAW stall on x7
        bus.issue_en  = 1'b1;
        bus.issue_reg = 5'd7;
        chk("iss7_pre", 32'h12345678, 32'h0, 1'b0);
        tick();
        bus.issue_en = 1'b0;
        bus.rs2_reg  = 5'd7;
        bus.rs2_used = 1'b1;
        chk("raw_hold", 32'h12345678, 32'h0, 1'b1);
        tick();
        chk("raw_hold2", 32'h12345678, 32'h0, 1'b1);
        wb(5'd7, 32'hA5);
        chk("raw_wb", 32'h12345678, Byp ? 32'hA5 : 32'h0, Byp ? 1'b0 : 1'b1);
        tick();
        bus.wb_en_in = 1'b0;
        chk("raw_done", 32'h12345678, 32'hA5, 1'b0);
        bus.rs2_used = 1'b0;

        // Three in flight on x3; a fourth issue stalls and is dropped
        bus.rs1_reg = 5'd3;
        for (int k = 0; k < 3; k++) begin
            bus.issue_en  = 1'b1;
            bus.issue_reg = 5'd3;
            chk($sformatf("iss3_%0d", k), 32'h0, 32'hA5, 1'b0);
            tick();
        end
        chk("iss3_full", 32'h0, 32'hA5, 1'b1);
        tick();
        bus.issue_en = 1'b0;
        bus.rs1_used = 1'b1;
        chk("pend3", 32'h0, 32'hA5, 1'b1);
        wb(5'd3, 32'h31);
        tick();
        bus.wb_en_in = 1'b0;
        chk("wb3_1", 32'h31, 32'hA5, 1'b1);
        wb(5'd3, 32'h32);
        tick();
        bus.wb_en_in = 1'b0;
        chk("wb3_2", 32'h32, 32'hA5, 1'b1);
        wb(5'd3, 32'h33);
        chk("wb3_3pre", Byp ? 32'h33 : 32'h32, 32'hA5, Byp ? 1'b0 : 1'b1);
        tick();
        bus.wb_en_in = 1'b0;
        chk("wb3_3", 32'h33, 32'hA5, 1'b0);
        bus.rs1_used = 1'b0;

        // Simultaneous issue and writeback on x9 keeps the count at 1
        bus.rs1_reg   = 5'd9;
        bus.issue_en  = 1'b1;
        bus.issue_reg = 5'd9;
        tick();
        bus.issue_en = 1'b0;
        chk("iss9", 32'h0, 32'hA5, 1'b0);
        bus.issue_en  = 1'b1;
        bus.issue_reg = 5'd9;
        wb(5'd9, 32'h99);
        chk("sim_pre", Byp ? 32'h99 : 32'h0, 32'hA5, 1'b0);
        tick();
        bus.issue_en = 1'b0;
        bus.wb_en_in = 1'b0;
        bus.rs1_used = 1'b1;
        chk("sim_post", 32'h99, 32'hA5, 1'b1);
        wb(5'd9, 32'h9A);
        tick();
        bus.wb_en_in = 1'b0;
        chk("sim_drain", 32'h9A, 32'hA5, 1'b0);

        // Writeback at count 0 writes data and does not wrap
        bus.rs1_reg = 5'd4;
        wb(5'd4, 32'h55);
        tick();
        bus.wb_en_in = 1'b0;
        chk("wb_pend0", 32'h55, 32'hA5, 1'b0);

        // Two pending on x4, then reset between edges
        bus.rs1_used = 1'b0;
        for (int k = 0; k < 2; k++) begin
            bus.issue_en  = 1'b1;
            bus.issue_reg = 5'd4;
            tick();
        end
        bus.issue_en = 1'b0;
        bus.rs1_used = 1'b1;
        bus.rs2_reg  = 5'd5;
        chk("pend4", 32'h55, 32'h12345678, 1'b1);
        #3;
        reset = 1'b0;
        chk("mid_rst", 32'h0, 32'h0, 1'b0);
        #2;
        reset = 1'b1;
        tick();
        chk("post_rst", 32'h0, 32'h0, 1'b0);

        // Counting restarts from zero after reset
        bus.rs1_used  = 1'b0;
        bus.issue_en  = 1'b1;
        bus.issue_reg = 5'd4;
        tick();
        bus.issue_en = 1'b0;
        bus.rs1_used = 1'b1;
        chk("rst_recount", 32'h0, 32'h0, 1'b1);
        wb(5'd4, 32'h77);
        tick();
        bus.wb_en_in = 1'b0;
        chk("rst_drain", 32'h77, 32'h0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
